mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Parametrised MEM stage with a real load/store unit. Sits between the EX/MEM and MEM/WB pipeline registers.
//  - Issues byte/half/word loads and stores to a data-memory bus with req/gnt/rvalid handshakes.
//  - Sign/zero-extends load data and generates store byte enables.
//  - Detects misalignment, bus errors and timeouts; stalls EX while an access is outstanding; supports flush.
// PARAMETERS
//  XLEN        32   data/register width (32 only; other values rejected by elaboration check)
//  ADDR_W      32   data-memory byte address width
//  REG_AW      5    register-file address width
//  TIMEOUT_CYC 255  max cycles in WAIT before access fault; 0 disables the timeout
// PORTS
//  clk            in   1        clock
//  arst_n         in   1        reset, synchronous, active-low
//  flush_i        in   1        kill the current and in-flight instruction (trap/branch redirect)
//  ex_valid_i     in   1        EX presents an instruction
//  ex_ready_o     out  1        stage can accept (state==IDLE)
//  funct3_i       in   3        000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_r_ena_i    in   1        load
//  mem_w_ena_i    in   1        store (never set together with mem_r_ena_i)
//  mem_addr_i     in   ADDR_W   byte address
//  mem_w_data_i   in   XLEN     store data (unshifted, in low bits)
//  reg_w_ena_i    in   1        writeback enable from EX
//  reg_w_addr_i   in   REG_AW   rd
//  reg_w_data_i   in   XLEN     ALU result (used when not a load)
//  dmem_req_o     out  1        bus request
//  dmem_we_o      out  1        1 = store
//  dmem_addr_o    out  ADDR_W   word-aligned address (low 2 bits forced 0)
//  dmem_be_o      out  XLEN/8   byte enables
//  dmem_wdata_o   out  XLEN     store data shifted into byte lanes
//  dmem_gnt_i     in   1        request accepted
//  dmem_rvalid_i  in   1        response (read data or store ack)
//  dmem_rdata_i   in   XLEN     read word
//  dmem_err_i     in   1        bus error, qualified by dmem_rvalid_i
//  wb_valid_o     out  1        one-cycle pulse: result valid for MEM/WB
//  reg_w_ena_o    out  1        writeback enable (0 on exception)
//  reg_w_addr_o   out  REG_AW   rd
//  reg_w_data_o   out  XLEN     result
//  exc_o          out  1        exception flag, valid with wb_valid_o
//  exc_cause_o    out  4        4 ld-misalign, 5 ld-fault, 6 st-misalign, 7 st-fault
// BEHAVIOUR
//  - Reset (arst_n=0 at clk edge)
//    - state=IDLE; all outputs 0 except ex_ready_o=1; timeout counter and kill flag cleared.
//    - An outstanding bus access is abandoned; a late rvalid after reset is ignored.
//  - FSM IDLE -> REQ -> WAIT -> IDLE. Accept = ex_valid_i & ex_ready_o & !flush_i; fields captured on accept.
//  - Non-memory instruction, or misaligned access:
//    - Stays IDLE; next cycle wb_valid_o=1 with registered reg_w_* (latency 1).
//    - Misaligned means H with addr[0]!=0, or W with addr[1:0]!=0.
//    - Misaligned access: no bus request, exc_o=1, cause 4/6, reg_w_ena_o=0.
//  - Aligned load/store: next state REQ.
//    - dmem_req_o=1 with stable addr/we/be/wdata until dmem_gnt_i.
//    - Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111.
//    - dmem_wdata_o = data replicated to lanes: B {4{d[7:0]}}, H {2{d[15:0]}}.
//  - REQ & gnt: -> WAIT; dmem_req_o drops the following cycle. gnt and rvalid in the same cycle is legal.
//  - WAIT & rvalid: -> IDLE; next cycle wb_valid_o=1.
//    - Load: lane selected by addr[1:0], then sign- or zero-extended per funct3.
//    - Store: reg_w_ena_o=0.
//    - dmem_err_i=1: exc_o=1, cause 5/7, reg_w_ena_o=0.
//    - Min load latency: accept -> wb_valid_o = 3 cycles with gnt in REQ and rvalid the next cycle.
//  - Timeout: counter counts cycles in WAIT, clears on leaving WAIT.
//    - When it reaches TIMEOUT_CYC: -> IDLE, fault exception as above; a later stray rvalid is ignored in IDLE.
//  - Flush:
//    - In IDLE: result pending this cycle is suppressed (wb_valid_o held 0).
//    - In REQ before gnt: req dropped, -> IDLE, no result.
//    - In REQ with gnt in the same cycle, or in WAIT: kill flag set; wait for rvalid/timeout, then -> IDLE with wb_valid_o=0.
//  - ex_ready_o=0 in REQ and WAIT, and in IDLE while the kill flag is set.
//  - Outputs are registered; reg_w_* hold their value between pulses.
// TESTING
//  - LB addr 0x103, rdata 0x80xx_xxxx -> be 4'b1000, reg_w_data_o=0xFFFF_FF80; LBU -> 0x0000_0080.
//  - SH addr 0x202 data 0x1234, gnt cycle 1, rvalid cycle 2 -> be 4'b1100, wdata 0x1234_1234, wb pulse, reg_w_ena_o=0.
//  - LW addr 0x101 -> no dmem_req_o, wb_valid_o next cycle, exc_o=1 cause 4; SW addr 0x102 -> cause 6.
//  - TIMEOUT_CYC=8, gnt but no rvalid -> cause 5 after 8 WAIT cycles; rvalid at cycle 10 ignored.
//  - Flush in WAIT, rvalid 3 cycles later -> no wb_valid_o, ex_ready_o returns 1.
//  - arst_n low mid-WAIT -> all outputs 0, ex_ready_o=1; a back-to-back ADD result (0x5) arrives 1 cycle after accept.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: issues byte/half/word accesses over a req/gnt/rvalid
// data bus, aligns and extends load data, and reports misalignment, bus faults and timeouts.
module mem_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [2:0]        funct3_i,
  input  logic              mem_r_ena_i,
  input  logic              mem_w_ena_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]   mem_w_data_i,
  input  logic              reg_w_ena_i,
  input  logic [REG_AW-1:0] reg_w_addr_i,
  input  logic [XLEN-1:0]   reg_w_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_err_i,
  output logic              wb_valid_o,
  output logic              reg_w_ena_o,
  output logic [REG_AW-1:0] reg_w_addr_o,
  output logic [XLEN-1:0]   reg_w_data_o,
  output logic              exc_o,
  output logic [3:0]        exc_cause_o
);

  localparam int BE_W = XLEN / 8;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  generate
    if (XLEN != 32) begin : g_xlen_chk
      $error("mem_lsu supports XLEN=32 only");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              kill_q, kill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              ld_q;
  logic              rd_ena_q;
  logic [REG_AW-1:0] rd_q;

  logic              accept, is_mem, misal, tmo, done, done_err, suppress;
  logic [BE_W-1:0]   be_in;
  logic [XLEN-1:0]   wdata_in, lane, ld_ext;

  assign ex_ready_o = (state_q == S_IDLE) && !kill_q;
  assign dmem_req_o = (state_q == S_REQ);
  assign accept     = ex_valid_i && ex_ready_o && !flush_i;
  assign is_mem     = mem_r_ena_i || mem_w_ena_i;
  assign done_err   = tmo || (dmem_rvalid_i && dmem_err_i);
  assign suppress   = kill_q || flush_i;

  always_comb begin
    be_in    = '1;
    wdata_in = mem_w_data_i;
    misal    = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_in    = BE_W'(1) << mem_addr_i[1:0];
        wdata_in = {(XLEN/8){mem_w_data_i[7:0]}};
      end
      2'b01: begin
        be_in    = BE_W'(3) << mem_addr_i[1:0];
        wdata_in = {(XLEN/16){mem_w_data_i[15:0]}};
        misal    = mem_addr_i[0];
      end
      default: misal = (mem_addr_i[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    lane   = dmem_rdata_i >> {off_q, 3'b000};
    ld_ext = lane;
    case (f3_q[1:0])
      2'b00:   ld_ext = f3_q[2] ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                : {{(XLEN-8){lane[7]}}, lane[7:0]};
      2'b01:   ld_ext = f3_q[2] ? {{(XLEN-16){1'b0}}, lane[15:0]}
                                : {{(XLEN-16){lane[15]}}, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    cnt_d   = '0;
    tmo     = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (accept && is_mem && !misal) state_d = S_REQ;
      S_REQ: begin
        if (dmem_gnt_i && dmem_rvalid_i) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else if (dmem_gnt_i) begin
          state_d = S_WAIT;
          if (flush_i) kill_d = 1'b1;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_W'(TO_LAST)) begin
          state_d = S_IDLE;
          done    = 1'b1;
          tmo     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (flush_i) kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) kill_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      f3_q         <= '0;
      off_q        <= '0;
      ld_q         <= 1'b0;
      rd_ena_q     <= 1'b0;
      rd_q         <= '0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      reg_w_ena_o  <= 1'b0;
      reg_w_addr_o <= '0;
      reg_w_data_o <= '0;
      exc_o        <= 1'b0;
      exc_cause_o  <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      if (accept) begin
        f3_q     <= funct3_i;
        off_q    <= mem_addr_i[1:0];
        ld_q     <= mem_r_ena_i;
        rd_ena_q <= reg_w_ena_i;
        rd_q     <= reg_w_addr_i;
        if (is_mem && !misal) begin
          dmem_we_o    <= mem_w_ena_i;
          dmem_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
          dmem_be_o    <= be_in;
          dmem_wdata_o <= wdata_in;
        end else begin
          // Non-memory ops and misaligned accesses retire straight from IDLE.
          wb_valid_o   <= 1'b1;
          reg_w_ena_o  <= reg_w_ena_i && !is_mem;
          reg_w_addr_o <= reg_w_addr_i;
          reg_w_data_o <= reg_w_data_i;
          exc_o        <= is_mem;
          exc_cause_o  <= !is_mem ? 4'd0 : (mem_w_ena_i ? 4'd6 : 4'd4);
        end
      end else if (done && !suppress) begin
        wb_valid_o   <= 1'b1;
        reg_w_ena_o  <= rd_ena_q && ld_q && !done_err;
        reg_w_addr_o <= rd_q;
        reg_w_data_o <= ld_q ? ld_ext : '0;
        exc_o        <= done_err;
        exc_cause_o  <= !done_err ? 4'd0 : (ld_q ? 4'd5 : 4'd7);
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: table of single-access vectors plus hand-written
// sequences for timeout, flush, same-cycle gnt/rvalid and mid-access reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        flush_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [2:0]  funct3_i;
  logic        mem_r_ena_i;
  logic        mem_w_ena_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_w_data_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_err_i;
  logic        wb_valid_o;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        exc_o;
  logic [3:0]  exc_cause_o;

  mem_lsu #(.XLEN(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .arst_n(arst_n), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .funct3_i(funct3_i),
    .mem_r_ena_i(mem_r_ena_i), .mem_w_ena_i(mem_w_ena_i), .mem_addr_i(mem_addr_i),
    .mem_w_data_i(mem_w_data_i), .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i),
    .reg_w_data_i(reg_w_data_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_err_i(dmem_err_i), .wb_valid_o(wb_valid_o), .reg_w_ena_o(reg_w_ena_o),
    .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o), .exc_o(exc_o),
    .exc_cause_o(exc_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic        exp_ena;
    logic [31:0] exp_data;
    logic        exp_exc;
    logic [3:0]  exp_cause;
  } vec_t;

  vec_t  vecs[15];
  int    total = 0;
  int    passed = 0;
  string ctx = "init";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s/%s: got %h expected %h", ctx, nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic ld, input logic st,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] alu);
    ex_valid_i = 1'b1; funct3_i = f3; mem_r_ena_i = ld; mem_w_ena_i = st;
    mem_addr_i = addr; mem_w_data_i = wd; reg_w_ena_i = 1'b1;
    reg_w_addr_i = rd; reg_w_data_i = alu;
    step();
    ex_valid_i = 1'b0; mem_r_ena_i = 1'b0; mem_w_ena_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [4:0] rd;
    rd = 5'(idx + 1);
    ctx = $sformatf("vec%0d", idx);
    issue(v.f3, v.ld, v.st, v.addr, v.wdata, rd, 32'hA5A5_0000 | 32'(idx));
    if (v.bus) begin
      chk("req", 32'(dmem_req_o), 32'd1);
      chk("ready_busy", 32'(ex_ready_o), 32'd0);
      chk("addr", dmem_addr_o, v.addr & ~32'h3);
      chk("we", 32'(dmem_we_o), 32'(v.st));
      chk("be", 32'(dmem_be_o), 32'(v.be));
      if (v.st) chk("wdata", dmem_wdata_o, v.exp_wdata);
      if (idx % 2 == 1) begin
        step();
        chk("req_hold", 32'(dmem_req_o), 32'd1);
        chk("be_hold", 32'(dmem_be_o), 32'(v.be));
      end
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      chk("req_drop", 32'(dmem_req_o), 32'd0);
      chk("wb_early", 32'(wb_valid_o), 32'd0);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rdata; dmem_err_i = v.err;
      step();
      dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
    end else begin
      chk("no_req", 32'(dmem_req_o), 32'd0);
    end
    chk("wb_valid", 32'(wb_valid_o), 32'd1);
    chk("ena", 32'(reg_w_ena_o), 32'(v.exp_ena));
    chk("rd", 32'(reg_w_addr_o), 32'(rd));
    chk("exc", 32'(exc_o), 32'(v.exp_exc));
    if (v.exp_exc) chk("cause", 32'(exc_cause_o), 32'(v.exp_cause));
    if (v.exp_ena) chk("data", reg_w_data_o, v.exp_data);
    step();
    chk("wb_pulse", 32'(wb_valid_o), 32'd0);
    chk("ready_after", 32'(ex_ready_o), 32'd1);
  endtask

  initial begin
    //          f3    ld   st   addr          wdata         rdata         err  bus  be       exp_wdata     ena  data          exc  cause
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'hA5A5_0000, 1'b0, 4'd0};
    vecs[1]  = '{3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 1'b0, 1'b1, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 4'd0};
    vecs[2]  = '{3'b100, 1'b1, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 1'b0, 1'b1, 4'b1000, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 4'd0};
    vecs[3]  = '{3'b001, 1'b1, 1'b0, 32'h102, 32'h0, 32'h8001_7FFF, 1'b0, 1'b1, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 4'd0};
    vecs[4]  = '{3'b101, 1'b1, 1'b0, 32'h100, 32'h0, 32'h1234_F00D, 1'b0, 1'b1, 4'b0011, 32'h0, 1'b1, 32'h0000_F00D, 1'b0, 4'd0};
    vecs[5]  = '{3'b010, 1'b1, 1'b0, 32'h204, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'd0};
    vecs[6]  = '{3'b000, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0000_7F00, 1'b0, 1'b1, 4'b0010, 32'h0, 1'b1, 32'h0000_007F, 1'b0, 4'd0};
    vecs[7]  = '{3'b001, 1'b0, 1'b1, 32'h202, 32'hFFFF_1234, 32'h0, 1'b0, 1'b1, 4'b1100, 32'h1234_1234, 1'b0, 32'h0, 1'b0, 4'd0};
    vecs[8]  = '{3'b000, 1'b0, 1'b1, 32'h201, 32'h1234_56AB, 32'h0, 1'b0, 1'b1, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0, 1'b0, 4'd0};
    vecs[9]  = '{3'b010, 1'b0, 1'b1, 32'h208, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 4'd0};
    vecs[10] = '{3'b010, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd4};
    vecs[11] = '{3'b010, 1'b0, 1'b1, 32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd6};
    vecs[12] = '{3'b001, 1'b1, 1'b0, 32'h103, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd4};
    vecs[13] = '{3'b010, 1'b1, 1'b0, 32'h20C, 32'h0, 32'h1111_1111, 1'b1, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, 4'd5};
    vecs[14] = '{3'b000, 1'b0, 1'b1, 32'h20D, 32'h0000_0055, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h5555_5555, 1'b0, 32'h0, 1'b1, 4'd7};

    arst_n = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0; funct3_i = '0;
    mem_r_ena_i = 1'b0; mem_w_ena_i = 1'b0; mem_addr_i = '0; mem_w_data_i = '0;
    reg_w_ena_i = 1'b0; reg_w_addr_i = '0; reg_w_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; dmem_err_i = 1'b0;
    step(); step();
    ctx = "reset";
    chk("ready", 32'(ex_ready_o), 32'd1);
    chk("req", 32'(dmem_req_o), 32'd0);
    chk("be", 32'(dmem_be_o), 32'd0);
    chk("wb_valid", 32'(wb_valid_o), 32'd0);
    chk("exc", 32'(exc_o), 32'd0);
    arst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Timeout: gnt but no rvalid -> fault after 8 WAIT cycles, stray rvalid ignored.
    ctx = "timeout";
    issue(3'b010, 1'b1, 1'b0, 32'h300, 32'h0, 5'd7, 32'h0);
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    chk("wb_w1", 32'(wb_valid_o), 32'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("wb_wait", 32'(wb_valid_o), 32'd0);
      chk("ready_wait", 32'(ex_ready_o), 32'd0);
    end
    step();
    chk("wb_valid", 32'(wb_valid_o), 32'd1);
    chk("exc", 32'(exc_o), 32'd1);
    chk("cause", 32'(exc_cause_o), 32'd5);
    chk("ena", 32'(reg_w_ena_o), 32'd0);
    chk("ready", 32'(ex_ready_o), 32'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    step(); dmem_rvalid_i = 1'b0;
    chk("stray_wb", 32'(wb_valid_o), 32'd0);
    chk("stray_req", 32'(dmem_req_o), 32'd0);
    step();
    chk("stray_wb2", 32'(wb_valid_o), 32'd0);

    // Flush in WAIT, response arrives later and is dropped.
    ctx = "flush_wait";
    issue(3'b010, 1'b1, 1'b0, 32'h400, 32'h0, 5'd8, 32'h0);
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("ready_killed", 32'(ex_ready_o), 32'd0);
    step(); step();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    step(); dmem_rvalid_i = 1'b0;
    chk("wb", 32'(wb_valid_o), 32'd0);
    chk("ready", 32'(ex_ready_o), 32'd1);
    step();
    chk("wb2", 32'(wb_valid_o), 32'd0);

    // Flush in REQ before gnt.
    ctx = "flush_req";
    issue(3'b010, 1'b1, 1'b0, 32'h500, 32'h0, 5'd9, 32'h0);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("req", 32'(dmem_req_o), 32'd0);
    chk("ready", 32'(ex_ready_o), 32'd1);
    chk("wb", 32'(wb_valid_o), 32'd0);
    step();
    chk("wb2", 32'(wb_valid_o), 32'd0);

    // Flush with an accept in IDLE suppresses the result.
    ctx = "flush_idle";
    flush_i = 1'b1;
    issue(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd10, 32'h77);
    flush_i = 1'b0;
    chk("wb", 32'(wb_valid_o), 32'd0);

    // gnt and rvalid in the same REQ cycle.
    ctx = "gnt_rvalid";
    issue(3'b100, 1'b1, 1'b0, 32'h502, 32'h0, 5'd11, 32'h0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h00AB_0000;
    step();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("wb", 32'(wb_valid_o), 32'd1);
    chk("data", reg_w_data_o, 32'h0000_00AB);
    chk("ena", 32'(reg_w_ena_o), 32'd1);
    chk("req", 32'(dmem_req_o), 32'd0);

    // Reset mid-WAIT, then back-to-back ADD with a late stray rvalid.
    ctx = "reset_wait";
    issue(3'b010, 1'b1, 1'b0, 32'h600, 32'h0, 5'd12, 32'h0);
    dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
    arst_n = 1'b0; step();
    chk("ready", 32'(ex_ready_o), 32'd1);
    chk("req", 32'(dmem_req_o), 32'd0);
    chk("we", 32'(dmem_we_o), 32'd0);
    chk("addr", dmem_addr_o, 32'd0);
    chk("be", 32'(dmem_be_o), 32'd0);
    chk("wdata", dmem_wdata_o, 32'd0);
    chk("wb", 32'(wb_valid_o), 32'd0);
    chk("ena", 32'(reg_w_ena_o), 32'd0);
    chk("rd", 32'(reg_w_addr_o), 32'd0);
    chk("data", reg_w_data_o, 32'd0);
    chk("exc", 32'(exc_o), 32'd0);
    chk("cause", 32'(exc_cause_o), 32'd0);
    arst_n = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
    issue(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 32'h5);
    dmem_rvalid_i = 1'b0;
    chk("add_wb", 32'(wb_valid_o), 32'd1);
    chk("add_data", reg_w_data_o, 32'h5);
    chk("add_rd", 32'(reg_w_addr_o), 32'd3);
    chk("add_ena", 32'(reg_w_ena_o), 32'd1);
    chk("add_exc", 32'(exc_o), 32'd0);
    step();
    chk("add_pulse", 32'(wb_valid_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
